signed_operand_conditioner: RTL and testbench
=============================================

# signed_operand_conditioner

Parametrised front end for the signed multiplier datapath. It accepts operand pairs through a valid/ready handshake and converts each operand from two's complement to magnitude. It computes the product sign and zero flag, then queues the results in a DEPTH-entry elastic buffer for the unsigned multiplier core. It generalises the single-operand, enable-gated converter to two operands, selectable signed/unsigned mode, backpressure and buffering.

## Interface
- WIDTH, 12, operand width in bits (≥2)
- DEPTH, 2, output buffer entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of the buffer; has priority over push and pop
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept this cycle
- in_a, in_b  in  WIDTH  operands
- in_signed  in  1  1 = two's complement, 0 = unsigned pass-through (sampled with the pair)
- out_valid  out  1  head entry present
- out_ready  in  1  consumer takes head this cycle
- out_mag_a, out_mag_b  out  WIDTH  unsigned magnitudes
- out_neg  out  1  product is negative
- out_zero  out  1  at least one magnitude is zero
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = (count < DEPTH) | out_ready. When full, a push is allowed in the same cycle as a pop.
- Conversion is combinational on the input side, and the result is written into the buffer at the write pointer:
  - Signed mode, sign bit set: mag = (~x)+1, truncated to WIDTH. Otherwise mag = x.
  - The most-negative value 2^(WIDTH-1) maps to the unsigned magnitude 2^(WIDTH-1). There is no overflow and no error flag.
  - Unsigned mode: mag = x.
- out_zero = (mag_a == 0) | (mag_b == 0).
- out_neg = in_signed & (a[W-1] ^ b[W-1]) & ~out_zero. A zero product is never negative.
- Buffer behaviour:
  - Circular, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - count is tracked explicitly: +1 on push only, −1 on pop only, unchanged on both or neither.
  - out_valid = (count != 0). The out_* data are driven from the head entry.
- Head data is stable while out_valid & ~out_ready.
- A push into an empty buffer is visible at the outputs on the next cycle. There is no bypass.
- clear: pointers and count go to 0 and out_valid drops on the next edge. Any push or pop in that cycle is discarded.
- No state machine beyond the buffer occupancy (EMPTY / PARTIAL / FULL, derived from count).

## Timing
- Reset (reset_n low, asynchronous): count=0, pointers=0, out_valid=0. in_ready then equals out_ready, so it is 1 when the consumer is ready.
- Storage contents are don't-care after reset. out_mag_a, out_mag_b, out_neg and out_zero read 0 after reset, because storage is reset to 0.
- Reset deasserted mid-stream: all queued entries are lost, and the first push after release appears one cycle later.
- Latency is one cycle from push to out_valid when the buffer is empty.
- Throughput is one pair per cycle, sustained with out_ready held high.
- Simultaneous push and pop:
  - Empty: push only, because no pop is possible.
  - Full: both proceed, count stays DEPTH, and pointers advance.
- Inputs are sampled only on push. Changes on in_a, in_b or in_signed while in_ready=0 have no effect.

## Structure
- Shared package: a localparam for the pointer width, a function for the count width, and a struct bundling {mag_a, mag_b, neg, zero} as one buffer entry, of width 2·WIDTH+2.
- Sub-module `abs_convert`: parametrised WIDTH, with inputs x and is_signed, outputs mag and is_zero. It is instantiated twice.
- The top level holds the combine logic, the circular buffer and the occupancy counter.

## Test plan
All scenarios use WIDTH=12 and DEPTH=2.
- Signed pair a=0xFFF (−1), b=0x003 → one cycle later: mag_a=0x001, mag_b=0x003, neg=1, zero=0, count=1.
- Most-negative value, signed a=0x800, b=0x800 → mag_a=0x800, mag_b=0x800, neg=0. Then a=0x800, b=0x001 → neg=1.
- Zero sign suppression, signed a=0x000, b=0xFFE → mag_b=0x002, zero=1, neg=0. Unsigned a=0xFFF, b=0x800 → mags unchanged, neg=0.
- Backpressure: out_ready=0, push 3 pairs → the first two are accepted, in_ready=0 after count=2, and the third is held. Raise out_ready → the entries drain in order, and the third is accepted in the same cycle as the first pop with count staying at 2.
- Full throughput: out_ready=1 with 8 back-to-back pairs → 8 outputs in order on consecutive cycles, count ≤1, and pointer wrap is exercised.
- Mid-stream disruption: assert reset_n low asynchronously with count=2 → out_valid=0 and count=0 immediately. Separately, clear with a simultaneous push → the buffer is empty on the next cycle and the pushed pair is discarded.

Source files
------------

// File: rtl/signed_operand_conditioner_pkg.sv
// signed_operand_conditioner shared types
// default widths, buffer entry layout, occupancy encoding
package signed_operand_conditioner_pkg;

    localparam int OP_W      = 12;
    localparam int BUF_DEPTH = 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);

    typedef struct packed {
        logic [OP_W-1:0] mag_a;
        logic [OP_W-1:0] mag_b;
        logic            neg;
        logic            zero;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/signed_operand_conditioner_abs_convert.sv
// abs_convert
// two's complement (or pass-through) to magnitude
module abs_convert #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] x,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             is_zero
);

    // negate only negative signed values; most-negative maps to itself
    always_comb begin
        mag = x;
        if (is_signed && x[WIDTH-1]) begin
            mag = ~x + WIDTH'(1);
        end
        is_zero = (mag == '0);
    end

endmodule

// File: rtl/signed_operand_conditioner.sv
// signed_operand_conditioner
// operand magnitude/sign front end with elastic output buffer
module signed_operand_conditioner
    import signed_operand_conditioner_pkg::*;
#(
    parameter int WIDTH = OP_W,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    input  logic                        in_signed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_mag_a,
    output logic [WIDTH-1:0]            out_mag_b,
    output logic                        out_neg,
    output logic                        out_zero,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = (DEPTH == BUF_DEPTH) ? PTR_W : $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             zero_a;
    logic             zero_b;
    entry_t           wr_entry;
    entry_t           head;
    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    occ_t             occ;
    logic             push;
    logic             pop;

    abs_convert #(.WIDTH(WIDTH)) u_abs_a (
        .x         (in_a),
        .is_signed (in_signed),
        .mag       (mag_a),
        .is_zero   (zero_a)
    );

    abs_convert #(.WIDTH(WIDTH)) u_abs_b (
        .x         (in_b),
        .is_signed (in_signed),
        .mag       (mag_b),
        .is_zero   (zero_b)
    );

    // combine both operands into one entry; a zero product is never negative
    always_comb begin
        wr_entry       = '0;
        wr_entry.mag_a = mag_a;
        wr_entry.mag_b = mag_b;
        wr_entry.zero  = zero_a | zero_b;
        wr_entry.neg   = in_signed
                       & (in_a[WIDTH-1] ^ in_b[WIDTH-1])
                       & ~(zero_a | zero_b);
    end

    // occupancy class and handshake decode
    always_comb begin
        occ = OCC_PARTIAL;
        if (cnt == '0) begin
            occ = OCC_EMPTY;
        end else if (cnt == CW'(DEPTH)) begin
            occ = OCC_FULL;
        end
        out_valid = (occ != OCC_EMPTY);
        in_ready  = (occ != OCC_FULL) | out_ready;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // circular buffer, pointers and explicit occupancy count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // head entry drives the consumer side
    always_comb begin
        head      = mem[rd_ptr];
        out_mag_a = head.mag_a;
        out_mag_b = head.mag_b;
        out_neg   = head.neg;
        out_zero  = head.zero;
        count     = cnt;
    end

endmodule

// File: tb/tb_signed_operand_conditioner.sv
// tb_signed_operand_conditioner
// directed vectors with hand-computed expectations
module tb_signed_operand_conditioner;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_mag_a;
    logic [11:0] out_mag_b;
    logic        out_neg;
    logic        out_zero;
    logic [1:0]  count;

    int n_checks;
    int n_fail;

    signed_operand_conditioner #(.WIDTH(12), .DEPTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag_a (out_mag_a),
        .out_mag_b (out_mag_b),
        .out_neg   (out_neg),
        .out_zero  (out_zero),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // present a pair at the falling edge, take it on the rising edge,
    // then look 1 time unit later
    task automatic push_one(input logic [11:0] a,
                            input logic [11:0] b,
                            input logic s);
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag,
                              input logic [11:0] ma,
                              input logic [11:0] mb,
                              input logic neg,
                              input logic zero);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".mag_a"}, 32'(out_mag_a), 32'(ma));
        check({tag, ".mag_b"}, 32'(out_mag_b), 32'(mb));
        check({tag, ".neg"},   32'(out_neg),   32'(neg));
        check({tag, ".zero"},  32'(out_zero),  32'(zero));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.count", 32'(count), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.mag_a", 32'(out_mag_a), 32'd0);
        check("rst.mag_b", 32'(out_mag_b), 32'd0);
        check("rst.neg", 32'(out_neg), 32'd0);
        check("rst.zero", 32'(out_zero), 32'd0);
        reset_n = 1'b1;

        // conversion vectors, consumer always ready
        push_one(12'hFFF, 12'h003, 1'b1);
        check_head("neg1", 12'h001, 12'h003, 1'b1, 1'b0);
        check("neg1.count", 32'(count), 32'd1);
        push_one(12'h800, 12'h800, 1'b1);
        check_head("minmin", 12'h800, 12'h800, 1'b0, 1'b0);
        check("minmin.count", 32'(count), 32'd1);
        push_one(12'h800, 12'h001, 1'b1);
        check_head("minone", 12'h800, 12'h001, 1'b1, 1'b0);
        push_one(12'h000, 12'hFFE, 1'b1);
        check_head("zero", 12'h000, 12'h002, 1'b0, 1'b1);
        push_one(12'hFFF, 12'h800, 1'b0);
        check_head("uns", 12'hFFF, 12'h800, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("drain.valid", 32'(out_valid), 32'd0);
        check("drain.count", 32'(count), 32'd0);

        // backpressure: two accepted, third held until a pop
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_one(12'h010 + 12'(i), 12'h020 + 12'(i), 1'b0);
        end
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = 12'h012;
        in_b      = 12'h022;
        in_signed = 1'b0;
        #1;
        check("bp.count", 32'(count), 32'd2);
        check("bp.in_ready", 32'(in_ready), 32'd0);
        check("bp.head_a", 32'(out_mag_a), 32'h010);
        @(posedge clk);
        #1;
        in_a = 12'h7AA;
        check("bp.hold_count", 32'(count), 32'd2);
        check("bp.hold_head", 32'(out_mag_a), 32'h010);
        @(negedge clk);
        in_a      = 12'h012;
        out_ready = 1'b1;
        #1;
        check("bp.ready_pop", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.both_count", 32'(count), 32'd2);
        check_head("bp.e1", 12'h011, 12'h021, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("bp.e2_count", 32'(count), 32'd1);
        check_head("bp.e2", 12'h012, 12'h022, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("bp.empty", 32'(out_valid), 32'd0);

        // sustained throughput across pointer wrap
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("tp.valid", 32'(out_valid), 32'd1);
                check("tp.count", 32'(count), 32'd1);
                check("tp.mag_a", 32'(out_mag_a), 32'(12'h300 + 12'(i - 1)));
                check("tp.mag_b", 32'(out_mag_b), 32'(12'h0A0 + 12'(i - 1)));
            end
            if (i < 8) begin
                in_valid  = 1'b1;
                in_a      = 12'h300 + 12'(i);
                in_b      = 12'h0A0 + 12'(i);
                in_signed = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("tp.empty", 32'(out_valid), 32'd0);

        // asynchronous reset while full
        out_ready = 1'b0;
        push_one(12'h055, 12'h066, 1'b0);
        push_one(12'h077, 12'h088, 1'b0);
        @(negedge clk);
        check("ar.full", 32'(count), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.count", 32'(count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        push_one(12'hF00, 12'h004, 1'b1);
        check("ar.after_count", 32'(count), 32'd1);
        check_head("ar.after", 12'h100, 12'h004, 1'b1, 1'b0);

        // clear wins over a simultaneous push
        @(negedge clk);
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 12'h123;
        in_b      = 12'h456;
        in_signed = 1'b0;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr.valid", 32'(out_valid), 32'd0);
        check("clr.count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        check("clr.stay", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
